// File: rtl/convolution_scheduler_if.sv
// Signal bundle between the IR loader / audio trigger source, the scheduler and ir_buffer.
// The slave modport is the scheduler's view; master is the environment's view.
interface convolution_scheduler_if;
    logic               ir_load_start;
    logic signed [15:0] ir_in;
    logic               ir_in_valid;
    logic               audio_trigger;

    logic [15:0]        ir_sample_index;
    logic signed [15:0] write_data;
    logic               write_enable;
    logic               ir_data_in_valid;
    logic [12:0]        first_ir_index;
    logic [12:0]        second_ir_index;
    logic               ir_vals_valid;
    logic [15:0]        tap_base;
    logic [15:0]        sweep_base;
    logic               impulse_in_memory_complete;
    logic               sweep_busy;
    logic               sweep_done;
    logic               overrun;
    logic [15:0]        overrun_count;

    modport slave (
        input  ir_load_start, ir_in, ir_in_valid, audio_trigger,
        output ir_sample_index, write_data, write_enable, ir_data_in_valid,
               first_ir_index, second_ir_index, ir_vals_valid, tap_base,
               sweep_base, impulse_in_memory_complete, sweep_busy,
               sweep_done, overrun, overrun_count
    );

    modport master (
        output ir_load_start, ir_in, ir_in_valid, audio_trigger,
        input  ir_sample_index, write_data, write_enable, ir_data_in_valid,
               first_ir_index, second_ir_index, ir_vals_valid, tap_base,
               sweep_base, impulse_in_memory_complete, sweep_busy,
               sweep_done, overrun, overrun_count
    );
endinterface

// File: rtl/convolution_scheduler.sv
// Loads the IR into ir_buffer, then sweeps all row pairs once per accepted audio trigger.
// Define CONV_OVERRUN_COUNT_EN to implement the saturating overrun_count (otherwise it reads 0).
//
// state  | meaning
// LOAD   | streaming IR samples into ir_buffer, write_enable high
// READY  | IR loaded, waiting for an audio trigger
// SWEEP  | presenting one row pair per cycle, r = 0..ROWS-1
// DRAIN  | waiting for the read pipeline to deliver the last row
module convolution_scheduler #(
    parameter int IMPULSE_LENGTH = 16000,
    parameter int READ_LATENCY   = 2
) (
    input  logic                     audio_clk,
    input  logic                     rst_in_n,
    convolution_scheduler_if.slave   sch
);
    localparam int          ROWS     = IMPULSE_LENGTH / 8;
    localparam logic [15:0] LAST_CNT = 16'(IMPULSE_LENGTH - 1);
    localparam logic [12:0] LAST_ROW = 13'(ROWS - 1);

    typedef enum logic [1:0] {S_LOAD, S_READY, S_SWEEP, S_DRAIN} state_t;

    state_t             state_q, state_d;
    logic [15:0]        count_q, count_d;
    logic [15:0]        hist_q, hist_d;
    logic [15:0]        base_q, base_d;
    logic [15:0]        widx_q, widx_d;
    logic signed [15:0] wdata_q, wdata_d;
    logic               wvalid_q, wvalid_d;
    logic               complete_q, complete_d;
    logic               pending_q, pending_d;
    logic               overrun_q, overrun_d;
    logic [15:0]        ovc_q, ovc_d;
    logic [12:0]        row_q, row_d;

    logic [READ_LATENCY-1:0] pv_q;
    logic [12:0]             prow_q [READ_LATENCY];

    logic        last_valid;
    logic [12:0] last_row;
    logic        done;
    logic        busy;

    assign last_valid = pv_q[READ_LATENCY-1];
    assign last_row   = prow_q[READ_LATENCY-1];
    assign done       = last_valid && (last_row == LAST_ROW);
    assign busy       = (state_q == S_SWEEP) || (state_q == S_DRAIN);

    always_ff @(posedge audio_clk or negedge rst_in_n) begin
        if (!rst_in_n) begin
            state_q    <= S_LOAD;
            count_q    <= '0;
            hist_q     <= '0;
            base_q     <= '0;
            widx_q     <= '0;
            wdata_q    <= '0;
            wvalid_q   <= 1'b0;
            complete_q <= 1'b0;
            pending_q  <= 1'b0;
            overrun_q  <= 1'b0;
            ovc_q      <= '0;
            row_q      <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            hist_q     <= hist_d;
            base_q     <= base_d;
            widx_q     <= widx_d;
            wdata_q    <= wdata_d;
            wvalid_q   <= wvalid_d;
            complete_q <= complete_d;
            pending_q  <= pending_d;
            overrun_q  <= overrun_d;
            ovc_q      <= ovc_d;
            row_q      <= row_d;
        end
    end

    // Read-latency pipeline: valid bit and row travel alongside the buffer read.
    always_ff @(posedge audio_clk or negedge rst_in_n) begin
        if (!rst_in_n) begin
            pv_q <= '0;
            for (int i = 0; i < READ_LATENCY; i++) prow_q[i] <= '0;
        end else begin
            pv_q[0]   <= (state_q == S_SWEEP);
            prow_q[0] <= row_q;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pv_q[i]   <= pv_q[i-1];
                prow_q[i] <= prow_q[i-1];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        hist_d     = hist_q;
        base_d     = base_q;
        widx_d     = widx_q;
        wdata_d    = wdata_q;
        wvalid_d   = 1'b0;
        complete_d = complete_q;
        pending_d  = pending_q;
        overrun_d  = 1'b0;
        ovc_d      = ovc_q;
        row_d      = row_q;

        if (busy) begin
            if (sch.audio_trigger) begin
                overrun_d = 1'b1;
`ifdef CONV_OVERRUN_COUNT_EN
                if (ovc_q != 16'hFFFF) ovc_d = ovc_q + 16'd1;
`endif
            end
            if (sch.ir_load_start) pending_d = 1'b1;
        end

        unique case (state_q)
            S_LOAD: begin
                if (sch.ir_load_start) begin
                    count_d    = '0;
                    complete_d = 1'b0;
                    hist_d     = '0;
                end else if (sch.ir_in_valid) begin
                    wvalid_d = 1'b1;
                    widx_d   = count_q;
                    wdata_d  = sch.ir_in;
                    count_d  = count_q + 16'd1;
                    if (count_q == LAST_CNT) begin
                        state_d    = S_READY;
                        complete_d = 1'b1;
                    end
                end
            end
            S_READY: begin
                // A load request in the same cycle as a trigger wins; the trigger is dropped.
                if (sch.ir_load_start) begin
                    state_d    = S_LOAD;
                    count_d    = '0;
                    complete_d = 1'b0;
                    hist_d     = '0;
                end else if (sch.audio_trigger) begin
                    base_d  = hist_q;
                    hist_d  = (hist_q == LAST_CNT) ? '0 : hist_q + 16'd1;
                    row_d   = '0;
                    state_d = S_SWEEP;
                end
            end
            S_SWEEP: begin
                if (row_q == LAST_ROW) state_d = S_DRAIN;
                else                   row_d   = row_q + 13'd1;
            end
            S_DRAIN: begin
                if (done) begin
                    if (pending_q || sch.ir_load_start) begin
                        state_d    = S_LOAD;
                        count_d    = '0;
                        complete_d = 1'b0;
                        hist_d     = '0;
                        pending_d  = 1'b0;
                    end else begin
                        state_d = S_READY;
                    end
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    assign sch.ir_sample_index            = widx_q;
    assign sch.write_data                 = wdata_q;
    assign sch.write_enable               = (state_q == S_LOAD);
    assign sch.ir_data_in_valid           = wvalid_q;
    assign sch.first_ir_index             = {row_q[11:0], 1'b0};
    assign sch.second_ir_index            = {row_q[11:0], 1'b1};
    assign sch.ir_vals_valid              = last_valid;
    assign sch.tap_base                   = last_valid ? {last_row, 3'b000} : 16'd0;
    assign sch.sweep_base                 = base_q;
    assign sch.impulse_in_memory_complete = complete_q;
    assign sch.sweep_busy                 = busy;
    assign sch.sweep_done                 = done;
    assign sch.overrun                    = overrun_q;
    assign sch.overrun_count              = ovc_q;
endmodule

// File: tb/tb_convolution_scheduler.sv
// Randomised bench for convolution_scheduler with a timing-based reference model.
module tb_convolution_scheduler;
    localparam int IL   = 64;
    localparam int RL   = 2;
    localparam int ROWS = IL / 8;

    localparam int M_LOAD  = 0;
    localparam int M_READY = 1;
    localparam int M_BUSY  = 2;

    logic audio_clk = 1'b0;
    logic rst_in_n  = 1'b0;
    always #5 audio_clk = ~audio_clk;

    convolution_scheduler_if sch();

    convolution_scheduler #(.IMPULSE_LENGTH(IL), .READ_LATENCY(RL)) dut (
        .audio_clk (audio_clk),
        .rst_in_n  (rst_in_n),
        .sch       (sch)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: sweep outputs follow from the cycle offset k since the trigger was accepted.
    int          m_mode, m_cnt, m_hist, m_base, m_k, m_idx_r, m_widx, m_ovc;
    logic        m_complete, m_pending, m_wv, m_ovp;
    logic [15:0] m_wdat;

    always @(posedge audio_clk or negedge rst_in_n) begin
        if (!rst_in_n) begin
            m_mode <= M_LOAD; m_cnt <= 0; m_hist <= 0; m_base <= 0; m_k <= 0;
            m_idx_r <= 0; m_widx <= 0; m_ovc <= 0; m_complete <= 1'b0;
            m_pending <= 1'b0; m_wv <= 1'b0; m_ovp <= 1'b0; m_wdat <= '0;
        end else begin
            m_wv  <= 1'b0;
            m_ovp <= 1'b0;
            case (m_mode)
                M_LOAD: begin
                    if (sch.ir_load_start) begin
                        m_cnt <= 0; m_complete <= 1'b0; m_hist <= 0;
                    end else if (sch.ir_in_valid) begin
                        m_wv <= 1'b1; m_widx <= m_cnt; m_wdat <= sch.ir_in;
                        m_cnt <= m_cnt + 1;
                        if (m_cnt == IL - 1) begin
                            m_mode <= M_READY; m_complete <= 1'b1;
                        end
                    end
                end
                M_READY: begin
                    if (sch.ir_load_start) begin
                        m_mode <= M_LOAD; m_cnt <= 0; m_complete <= 1'b0; m_hist <= 0;
                    end else if (sch.audio_trigger) begin
                        m_base <= m_hist; m_hist <= (m_hist + 1) % IL;
                        m_k <= 1; m_mode <= M_BUSY;
                    end
                end
                default: begin
                    if (sch.audio_trigger) begin
                        m_ovp <= 1'b1;
                        if (m_ovc < 65535) m_ovc <= m_ovc + 1;
                    end
                    if (sch.ir_load_start) m_pending <= 1'b1;
                    if (m_k == ROWS + RL) begin
                        m_idx_r <= ROWS - 1;
                        if (m_pending || sch.ir_load_start) begin
                            m_mode <= M_LOAD; m_cnt <= 0; m_complete <= 1'b0;
                            m_hist <= 0; m_pending <= 1'b0;
                        end else begin
                            m_mode <= M_READY;
                        end
                    end else begin
                        m_k <= m_k + 1;
                    end
                end
            endcase
        end
    end

    always @(negedge audio_clk) begin
        int   r;
        logic busy, vld;
        busy = (m_mode == M_BUSY);
        vld  = busy && (m_k >= RL + 1) && (m_k <= ROWS + RL);
        r    = busy ? ((m_k <= ROWS) ? m_k - 1 : ROWS - 1) : m_idx_r;
        chk("write_enable", 16'(sch.write_enable), 16'(m_mode == M_LOAD));
        chk("ir_data_in_valid", 16'(sch.ir_data_in_valid), 16'(m_wv));
        chk("ir_sample_index", sch.ir_sample_index, 16'(m_widx));
        chk("write_data", sch.write_data, m_wdat);
        chk("first_ir_index", 16'(sch.first_ir_index), 16'(2 * r));
        chk("second_ir_index", 16'(sch.second_ir_index), 16'(2 * r + 1));
        chk("ir_vals_valid", 16'(sch.ir_vals_valid), 16'(vld));
        chk("tap_base", sch.tap_base, vld ? 16'((m_k - 1 - RL) * 8) : 16'd0);
        chk("sweep_base", sch.sweep_base, 16'(m_base));
        chk("complete", 16'(sch.impulse_in_memory_complete), 16'(m_complete));
        chk("sweep_busy", 16'(sch.sweep_busy), 16'(busy));
        chk("sweep_done", 16'(sch.sweep_done), 16'(busy && m_k == ROWS + RL));
        chk("overrun", 16'(sch.overrun), 16'(m_ovp));
`ifdef CONV_OVERRUN_COUNT_EN
        chk("overrun_count", sch.overrun_count, 16'(m_ovc));
`else
        chk("overrun_count", sch.overrun_count, 16'd0);
`endif
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge audio_clk); #1;
            sch.ir_load_start = 1'b0; sch.audio_trigger = 1'b0; sch.ir_in_valid = 1'b0;
        end
    endtask

    task automatic pulse_trig();
        step(1);
        sch.audio_trigger = 1'b1;
    endtask

    task automatic pulse_ld();
        step(1);
        sch.ir_load_start = 1'b1;
    endtask

    task automatic load_ir(input int n, input int gap, input bit rnd);
        for (int i = 0; i < n; i++) begin
            step(1);
            sch.ir_in_valid = 1'b1;
            sch.ir_in = rnd ? 16'($urandom) : 16'(i);
            if (gap > 1) step(gap - 1);
        end
        step(2);
    endtask

    initial begin
        logic [15:0] exp_ovc;
`ifdef CONV_OVERRUN_COUNT_EN
        exp_ovc = 16'd1;
`else
        exp_ovc = 16'd0;
`endif
        sch.ir_load_start = 1'b0; sch.ir_in = '0; sch.ir_in_valid = 1'b0; sch.audio_trigger = 1'b0;
        step(3);
        chk("rst write_enable", 16'(sch.write_enable), 16'd1);
        chk("rst first_ir_index", 16'(sch.first_ir_index), 16'd0);
        rst_in_n = 1'b1;
        step(2);

        // Load 0..63 one every 2 cycles, then a stray 65th sample
        load_ir(IL, 2, 1'b0);
        chk("lit complete", 16'(sch.impulse_in_memory_complete), 16'd1);
        chk("lit last index", sch.ir_sample_index, 16'd63);
        load_ir(1, 1, 1'b1);

        // Sweep with overrun at t+5, next trigger at t+11
        pulse_trig();
        step(4);
        pulse_trig();
        step(1);
        chk("lit overrun", 16'(sch.overrun), 16'd1);
        chk("lit overrun_count", sch.overrun_count, exp_ovc);
        chk("lit first idx t+6", 16'(sch.first_ir_index), 16'd10);
        step(4);
        chk("lit sweep_done t+10", 16'(sch.sweep_done), 16'd1);
        chk("lit tap_base t+10", sch.tap_base, 16'd56);
        pulse_trig();
        step(1);
        chk("lit sweep_base 2nd", sch.sweep_base, 16'd1);
        step(12);
        chk("lit idx hold", 16'(sch.second_ir_index), 16'd15);

        // Load request mid-sweep
        pulse_trig();
        step(3);
        pulse_ld();
        step(6);
        chk("lit done before reload", 16'(sch.sweep_done), 16'd1);
        step(1);
        chk("lit reload write_enable", 16'(sch.write_enable), 16'd1);
        chk("lit reload complete", 16'(sch.impulse_in_memory_complete), 16'd0);
        load_ir(IL, 1, 1'b1);

        // Reset mid-sweep
        pulse_trig();
        step(5);
        step(1);
        rst_in_n = 1'b0;
        step(1);
        chk("lit rst valid", 16'(sch.ir_vals_valid), 16'd0);
        chk("lit rst done", 16'(sch.sweep_done), 16'd0);
        chk("lit rst write_enable", 16'(sch.write_enable), 16'd1);
        chk("lit rst overrun_count", sch.overrun_count, 16'd0);
        step(2);
        rst_in_n = 1'b1;
        load_ir(IL, 1, 1'b1);

        // 65 back-to-back sweeps, one trigger every 11 cycles
        for (int s = 0; s < IL + 1; s++) begin
            pulse_trig();
            step(1);
            if (s == IL - 1) chk("lit base 63", sch.sweep_base, 16'd63);
            if (s == IL)     chk("lit base wrap", sch.sweep_base, 16'd0);
            chk("lit no overrun", 16'(sch.overrun), 16'd0);
            step(9);
        end

        // Random traffic
        for (int c = 0; c < 4000; c++) begin
            step(1);
            sch.ir_in_valid   = ($urandom_range(1, 0) == 1);
            sch.ir_in         = 16'($urandom);
            sch.audio_trigger = ($urandom_range(9, 0) == 0);
            sch.ir_load_start = ($urandom_range(299, 0) == 0);
        end
        step(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
